// File: rtl/audio_pkg.sv
// Shared state codes, PWM defaults and PCM-to-duty conversion for the audio PWM player.
package audio_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] PLAY  = 2'd2;

  localparam int PWM_BITS_DEF = 8;
  localparam logic [PWM_BITS_DEF-1:0] MIDSCALE = PWM_BITS_DEF'(1 << (PWM_BITS_DEF-1));

  // Signed PCM to offset binary; the caller keeps as many top bits as its PWM needs.
  function automatic logic [15:0] pcm_to_duty(input logic [15:0] pcm);
    return {~pcm[15], pcm[14:0]};
  endfunction
endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO; pointers carry a wrap bit so full/empty need no extra state.
module sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  // A pop in the same cycle frees the slot, so a push on full is still taken.
  assign wr_en = push && !flush && (!full || pop);
  assign rd_en = pop && !flush && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/audio_pwm_player.sv
// Buffers bursty PCM samples and plays them at a fixed rate through a 1-bit PWM DAC.
module audio_pwm_player
  import audio_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SAMPLE_DIV  = 3125,
  parameter int PRIME_LEVEL = 8,
  parameter int PWM_BITS    = PWM_BITS_DEF
) (
  input  logic                   clk_25mhz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sample_valid,
  input  logic [15:0]            sample_in,
  output logic                   pwm_out,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   playing,
  output logic                   overflow,
  output logic                   underrun,
  input  logic                   clear_flags
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam logic [PWM_BITS-1:0] MID = {1'b1, {(PWM_BITS-1){1'b0}}};

  logic [1:0]          state_q, state_d;
  logic [CW-1:0]       scnt_q, scnt_d;
  logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
  logic [PWM_BITS-1:0] duty_next_q, duty_next_d, duty_active_q, duty_active_d;
  logic                pwm_q, pwm_d, play_q, play_d, ovf_q, ovf_d, udr_q, udr_d;
  logic                tick, push_req, pop, flush, full, empty;
  logic [15:0]         fifo_dout, dout_ob;

  assign tick    = (state_q == PLAY) && (scnt_q == CW'(SAMPLE_DIV-1));
  assign dout_ob = pcm_to_duty(fifo_dout);

  sample_fifo #(.DEPTH(DEPTH), .WIDTH(16)) u_fifo (
    .clk   (clk_25mhz),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .flush (flush),
    .din   (sample_in),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk_25mhz) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = PRIME;
      PRIME:   if (fifo_level >= LW'(PRIME_LEVEL)) state_d = PLAY;
      PLAY:    if (tick && empty) state_d = PRIME;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_comb begin
    push_req    = sample_valid && (state_q != IDLE);
    pop         = tick && !empty;
    flush       = (state_q == IDLE) || !enable;
    play_d      = (state_d == PLAY);
    duty_next_d = duty_next_q;
    if (!enable || state_q != PLAY) duty_next_d = MID;
    else if (tick)                  duty_next_d = empty ? MID : dout_ob[15 -: PWM_BITS];
  end

  // Sticky flags: a new event in the same cycle overrides clear_flags.
  always_comb begin
    scnt_d        = (tick || state_q != PLAY) ? '0 : scnt_q + CW'(1);
    pcnt_d        = pcnt_q + PWM_BITS'(1);
    duty_active_d = (pcnt_q == '1) ? duty_next_q : duty_active_q;
    pwm_d         = (pcnt_q < duty_active_q);
    ovf_d         = clear_flags ? 1'b0 : ovf_q;
    udr_d         = clear_flags ? 1'b0 : udr_q;
    if (push_req && full && !pop) ovf_d = 1'b1;
    if (tick && empty)            udr_d = 1'b1;
  end

  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      scnt_q        <= '0;
      pcnt_q        <= '0;
      duty_next_q   <= MID;
      duty_active_q <= MID;
      pwm_q         <= 1'b0;
      play_q        <= 1'b0;
      ovf_q         <= 1'b0;
      udr_q         <= 1'b0;
    end else begin
      scnt_q        <= scnt_d;
      pcnt_q        <= pcnt_d;
      duty_next_q   <= duty_next_d;
      duty_active_q <= duty_active_d;
      pwm_q         <= pwm_d;
      play_q        <= play_d;
      ovf_q         <= ovf_d;
      udr_q         <= udr_d;
    end
  end

  assign pwm_out  = pwm_q;
  assign playing  = play_q;
  assign overflow = ovf_q;
  assign underrun = udr_q;
endmodule

// File: tb/tb_audio_pwm_player.sv
// Bench for audio_pwm_player: queue-based reference model, conversion vector table, corner sequences.
module tb_audio_pwm_player;
  localparam int DIV = 300, DEPTH = 16, PL = 8, PB = 8;

  logic        clk = 1'b0;
  logic        reset, enable, sample_valid, clear_flags;
  logic [15:0] sample_in;
  logic        pwm_out, playing, overflow, underrun;
  logic [4:0]  fifo_level;

  audio_pwm_player #(.DEPTH(DEPTH), .SAMPLE_DIV(DIV), .PRIME_LEVEL(PL), .PWM_BITS(PB)) dut (
    .clk_25mhz(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample_in(sample_in), .pwm_out(pwm_out), .fifo_level(fifo_level), .playing(playing),
    .overflow(overflow), .underrun(underrun), .clear_flags(clear_flags)
  );

  always #20 clk = ~clk;

  // ---------------- reference model ----------------
  int          mq[$];
  int          m_st, m_scnt, m_pcnt, m_dn, m_da, m_lvl, m_stn;
  int          m_pops = 0;
  bit          m_pwm, m_ovf, m_udr, m_play, m_tick, m_popd;

  function automatic int to_duty(input logic [15:0] s);
    return (int'($signed(s)) + 32768) / 256;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_st = 0; m_scnt = 0; m_pcnt = 0; m_dn = 128; m_da = 128;
      m_pwm = 0; m_ovf = 0; m_udr = 0; m_play = 0;
    end else begin
      m_lvl  = mq.size();
      m_pwm  = (m_pcnt < m_da);
      if (m_pcnt == 255) m_da = m_dn;
      m_pcnt = (m_pcnt + 1) % 256;
      m_tick = (m_st == 2) && (m_scnt == DIV - 1);
      m_popd = m_tick && (m_lvl > 0);
      if (clear_flags) begin m_ovf = 0; m_udr = 0; end
      if (m_tick && m_lvl == 0) m_udr = 1;
      if (sample_valid && m_st != 0 && m_lvl == DEPTH && !m_popd) m_ovf = 1;
      if (!enable || m_st != 2) m_dn = 128;
      else if (m_tick)          m_dn = m_popd ? to_duty(16'(mq[0])) : 128;
      if (!enable)                           m_stn = 0;
      else if (m_st == 0)                    m_stn = 1;
      else if (m_st == 1)                    m_stn = (m_lvl >= PL) ? 2 : 1;
      else                                   m_stn = (m_tick && m_lvl == 0) ? 1 : 2;
      if (m_popd) begin void'(mq.pop_front()); m_pops++; end
      if (sample_valid && m_st != 0 && mq.size() < DEPTH) mq.push_back(int'(sample_in));
      if (!enable || m_st == 0) mq.delete();
      m_scnt = (m_st == 2 && !m_tick) ? m_scnt + 1 : 0;
      m_st   = m_stn;
      m_play = (m_stn == 2);
    end
  end

  // ---------------- checking helpers ----------------
  int n_tests = 0, n_fail = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    sample_valid = 1'b0;
    clear_flags  = 1'b0;
    if (chk_en) begin
      n_tests++;
      if (pwm_out !== m_pwm || fifo_level !== 5'(mq.size()) || playing !== m_play ||
          overflow !== m_ovf || underrun !== m_udr) begin
        n_fail++;
        $display("FAIL model @%0t: pwm %b/%b level %0d/%0d playing %b/%b ovf %b/%b udr %b/%b (got/expected)",
                 $time, pwm_out, m_pwm, fifo_level, mq.size(), playing, m_play,
                 overflow, m_ovf, underrun, m_udr);
      end
    end
  endtask

  task automatic push(input logic [15:0] s);
    sample_valid = 1'b1;
    sample_in    = s;
    cyc();
  endtask

  task automatic wait_pops(input int n);
    int k = 0;
    while (m_pops < n && k < 2000) begin cyc(); k++; end
    chk("pop wait bound", int'(m_pops >= n), 1);
  endtask

  task automatic wait_pre_tick();
    int k = 0;
    while (!(m_st == 2 && m_scnt == DIV - 1) && k < 1000) begin cyc(); k++; end
    chk("tick wait bound", int'(m_st == 2 && m_scnt == DIV - 1), 1);
  endtask

  task automatic wait_level(input int lvl, input int bound);
    int k = 0;
    while (mq.size() != lvl && k < bound) begin cyc(); k++; end
    chk("level wait bound", mq.size(), lvl);
  endtask

  // Counts high cycles over the first full PWM period that starts after now.
  task automatic measure(output int hi);
    int k = 0;
    hi = 0;
    cyc();
    while (m_pcnt != 0 && k < 300) begin cyc(); k++; end
    for (int i = 0; i < 256; i++) begin
      cyc();
      hi += int'(pwm_out);
    end
  endtask

  typedef struct { logic [15:0] s; int duty; } vec_t;
  vec_t vt[6];

  initial begin
    int hi, rate;
    vt[0] = '{16'h7FFF, 255};
    vt[1] = '{16'h8000, 0};
    vt[2] = '{16'h4000, 192};
    vt[3] = '{16'hC000, 64};
    vt[4] = '{16'h0100, 129};
    vt[5] = '{16'hFF80, 127};

    reset = 1; enable = 0; sample_valid = 0; clear_flags = 0; sample_in = 0;
    cyc(); cyc();
    chk_en = 1;
    chk("reset level", fifo_level, 0);
    chk("reset playing", playing, 0);
    chk("reset overflow", overflow, 0);
    chk("reset underrun", underrun, 0);
    chk("reset pwm", pwm_out, 0);

    // IDLE ignores pushes
    reset = 0;
    for (int i = 0; i < 3; i++) push(16'h1234);
    chk("idle push ignored", fifo_level, 0);
    chk("idle no overflow", overflow, 0);

    // Prime with 2 zeros then the vector table, each vector twice
    enable = 1; cyc();
    push(16'h0000); push(16'h0000);
    for (int i = 0; i < 3; i++) begin push(vt[i].s); push(vt[i].s); end
    chk("primed level", fifo_level, 8);
    chk("not yet playing", playing, 0);
    cyc();
    chk("playing after prime", playing, 1);
    for (int i = 3; i < 6; i++) begin push(vt[i].s); push(vt[i].s); end
    wait_pops(1);
    measure(hi);
    chk("zero sample duty", hi, 128);
    for (int i = 0; i < 6; i++) begin
      wait_pops(3 + 2 * i);
      measure(hi);
      chk($sformatf("vector %0d duty", i), hi, vt[i].duty);
    end

    // Overflow in PRIME/PLAY before any tick
    reset = 1; cyc(); reset = 0;
    cyc();
    for (int i = 0; i < 17; i++) push(16'h4000);
    chk("ovf level", fifo_level, 16);
    chk("ovf set", overflow, 1);
    clear_flags = 1; cyc();
    chk("ovf cleared", overflow, 0);
    sample_valid = 1; clear_flags = 1; sample_in = 16'h4000; cyc();
    chk("ovf event beats clear", overflow, 1);
    clear_flags = 1; cyc();
    chk("ovf cleared again", overflow, 0);

    // Full FIFO with push and tick together
    wait_pre_tick();
    push(16'h4000);
    chk("full push+pop level", fifo_level, 16);
    chk("full push+pop no ovf", overflow, 0);

    // Drain, then empty tick with a push in the same cycle
    wait_level(0, 6000);
    wait_pre_tick();
    push(16'h0000);
    chk("underrun set", underrun, 1);
    chk("no bypass level", fifo_level, 1);
    chk("back to prime", playing, 0);
    measure(hi);
    chk("underrun duty mid", hi, 128);

    // enable=0 mid-PLAY with level 5
    for (int i = 0; i < 7; i++) push(16'h7FFF);
    wait_level(5, 1500);
    chk("play level 5", fifo_level, 5);
    enable = 0; cyc();
    chk("disable level", fifo_level, 0);
    chk("disable playing", playing, 0);
    chk("disable keeps underrun", underrun, 1);
    measure(hi);
    chk("disable duty mid", hi, 128);

    // reset mid-PLAY with level 5
    enable = 1; cyc();
    for (int i = 0; i < 8; i++) push(16'h1000);
    wait_level(5, 1500);
    reset = 1; cyc(); reset = 0;
    chk("reset level mid-play", fifo_level, 0);
    chk("reset playing mid-play", playing, 0);
    chk("reset underrun mid-play", underrun, 0);
    chk("reset overflow mid-play", overflow, 0);

    // Randomised bursty traffic against the model
    enable = 1;
    rate = 3;
    for (int c = 0; c < 10000; c++) begin
      if (c % 500 == 0) begin
        case ($urandom_range(0, 3))
          0: rate = 1;
          1: rate = 3;
          2: rate = 4;
          default: rate = 60;
        endcase
      end
      sample_valid = ($urandom_range(0, 999) < rate);
      sample_in    = 16'($urandom);
      clear_flags  = ($urandom_range(0, 499) == 0);
      enable       = ($urandom_range(0, 2999) != 0);
      reset        = ($urandom_range(0, 4999) == 0);
      cyc();
    end
    reset = 0; enable = 1;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
